// File: rtl/wfg_core_pkg.sv
// Shared types and defaults for the waveform-generator core scheduler.
// Feature macro: WFG_CORE_SCHEDULER_SHADOW_EN (shadowed cfg fields).
package wfg_core_pkg;

  localparam int SUBW_DEF  = 16;
  localparam int SYNCW_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/wfg_core_wrap_counter.sv
// Up-counter that returns to zero once it reaches or passes its limit.
// Feature macro: WFG_CORE_SCHEDULER_SHADOW_EN (not used here).
module wfg_core_wrap_counter
  import wfg_core_pkg::*;
#(
  parameter int W = SYNCW_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         step,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         wrap
);

  // >= so a limit lowered below count wraps at once
  assign wrap = step && (count >= limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (step) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/wfg_core_scheduler.sv
// Subcycle and sync strobe scheduler of the waveform-generator core.
// Feature macro: WFG_CORE_SCHEDULER_SHADOW_EN (cfg latched per sync).
module wfg_core_scheduler
  import wfg_core_pkg::*;
#(
  parameter int SUBW  = SUBW_DEF,
  parameter int SYNCW = SYNCW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [SUBW-1:0]  subcycle_cfg_i,
  input  logic [SYNCW-1:0] sync_cfg_i,
  output logic             active_o,
  output logic             subcycle_o,
  output logic             sync_o,
  output logic [SUBW-1:0]  subcycle_cnt_o,
  output logic [SYNCW-1:0] sync_cnt_o
);

  state_t state;
  state_t state_nxt;
  logic   entry;
  logic   run_go;
  logic   sub_wrap;
  logic   sync_wrap;

  logic [SUBW-1:0]  sub_lim;
  logic [SYNCW-1:0] sync_lim;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    entry     = 1'b0;
    run_go    = 1'b0;
    unique case (state)
      IDLE: begin
        if (en_i) begin
          state_nxt = RUN;
          entry     = 1'b1;
        end
      end
      RUN: begin
        if (en_i) run_go = 1'b1;
        else      state_nxt = IDLE;
      end
    endcase
  end

`ifdef WFG_CORE_SCHEDULER_SHADOW_EN
  logic [SUBW-1:0]  sub_sh;
  logic [SYNCW-1:0] sync_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_sh  <= '0;
      sync_sh <= '0;
    end else if (entry || sync_wrap) begin
      sub_sh  <= subcycle_cfg_i;
      sync_sh <= sync_cfg_i;
    end
  end

  assign sub_lim  = sub_sh;
  assign sync_lim = sync_sh;
`else
  assign sub_lim  = subcycle_cfg_i;
  assign sync_lim = sync_cfg_i;
`endif

  // Counters are cleared in IDLE, on entry and on leaving RUN
  wfg_core_wrap_counter #(.W(SUBW)) u_sub (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (!run_go),
    .step  (run_go),
    .limit (sub_lim),
    .count (subcycle_cnt_o),
    .wrap  (sub_wrap)
  );

  wfg_core_wrap_counter #(.W(SYNCW)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (!run_go),
    .step  (sub_wrap),
    .limit (sync_lim),
    .count (sync_cnt_o),
    .wrap  (sync_wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_o   <= 1'b0;
      subcycle_o <= 1'b0;
      sync_o     <= 1'b0;
    end else begin
      active_o   <= (state_nxt == RUN);
      subcycle_o <= entry | sub_wrap;
      sync_o     <= entry | sync_wrap;
    end
  end

endmodule

// File: tb/tb_wfg_core_scheduler.sv
// Randomised and directed bench for wfg_core_scheduler with a
// behavioural model. Feature macro: WFG_CORE_SCHEDULER_SHADOW_EN.
module tb_wfg_core_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_i;
  logic [15:0] subcycle_cfg_i;
  logic [7:0]  sync_cfg_i;
  logic        active_o;
  logic        subcycle_o;
  logic        sync_o;
  logic [15:0] subcycle_cnt_o;
  logic [7:0]  sync_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  int m_act, m_sstb, m_ystb, m_scnt, m_ycnt;
  int m_slim, m_ylim;

  wfg_core_scheduler #(.SUBW(16), .SYNCW(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en_i           (en_i),
    .subcycle_cfg_i (subcycle_cfg_i),
    .sync_cfg_i     (sync_cfg_i),
    .active_o       (active_o),
    .subcycle_o     (subcycle_o),
    .sync_o         (sync_o),
    .subcycle_cnt_o (subcycle_cnt_o),
    .sync_cnt_o     (sync_cnt_o)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_zero();
    m_act  = 0;
    m_sstb = 0;
    m_ystb = 0;
    m_scnt = 0;
    m_ycnt = 0;
  endtask

  // One clock of the scheduler rules, using inputs seen at the edge
  task automatic model_step();
    int es, ey;
    if (!rst_n || !en_i) begin
      model_zero();
    end else if (m_act == 0) begin
      m_act  = 1;
      m_sstb = 1;
      m_ystb = 1;
      m_scnt = 0;
      m_ycnt = 0;
      m_slim = int'(subcycle_cfg_i);
      m_ylim = int'(sync_cfg_i);
    end else begin
`ifdef WFG_CORE_SCHEDULER_SHADOW_EN
      es = m_slim;
      ey = m_ylim;
`else
      es = int'(subcycle_cfg_i);
      ey = int'(sync_cfg_i);
`endif
      m_ystb = 0;
      if (m_scnt >= es) begin
        m_scnt = 0;
        m_sstb = 1;
        if (m_ycnt >= ey) begin
          m_ycnt = 0;
          m_ystb = 1;
          m_slim = int'(subcycle_cfg_i);
          m_ylim = int'(sync_cfg_i);
        end else begin
          m_ycnt++;
        end
      end else begin
        m_scnt++;
        m_sstb = 0;
      end
    end
  endtask

  task automatic compare_all();
    chk("active", 32'(active_o), m_act);
    chk("subcycle", 32'(subcycle_o), m_sstb);
    chk("sync", 32'(sync_o), m_ystb);
    chk("sub_cnt", 32'(subcycle_cnt_o), m_scnt);
    chk("sync_cnt", 32'(sync_cnt_o), m_ycnt);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic chk_list(input string nm, input int q[$],
                          input int e[4]);
    chk({nm, "_n"}, 32'(q.size()), 4);
    for (int i = 0; i < 4; i++)
      chk(nm, (i < q.size()) ? 32'(q[i]) : 32'hffff_ffff, e[i]);
  endtask

  int subq[$];
  int synq[$];
  int ycq[$];
  int gapq[$];
  int e_sub[4];
  int e_syn[4];
  int e_yc[4];
  int e_gap[4];
  int g;
  bit found;

  initial begin
    rst_n          = 1'b0;
    en_i           = 1'b1;
    subcycle_cfg_i = 16'd3;
    sync_cfg_i     = 8'd1;
    model_zero();
    m_slim = 0;
    m_ylim = 0;
    #1;
    compare_all();
    repeat (3) cyc();
    rst_n = 1'b1;

    // Subcycle 3, sync 1: en sampled at edge 0
    for (int e = 0; e < 14; e++) begin
      cyc();
      if (subcycle_o) begin
        subq.push_back(e + 1);
        ycq.push_back(int'(sync_cnt_o));
      end
      if (sync_o) synq.push_back(e + 1);
    end
    e_sub = '{1, 5, 9, 13};
    e_yc  = '{0, 1, 0, 1};
    chk_list("t1_sub", subq, e_sub);
    chk_list("t1_ycnt", ycq, e_yc);
    chk("t1_nsync", 32'(synq.size()), 2);
    if (synq.size() == 2) begin
      chk("t1_sync0", 32'(synq[0]), 1);
      chk("t1_sync1", 32'(synq[1]), 9);
    end

    // Subcycle 0, sync 0: both strobes every RUN cycle
    en_i = 1'b0;
    cyc();
    subcycle_cfg_i = 16'd0;
    sync_cfg_i     = 8'd0;
    en_i           = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t2_sub", 32'(subcycle_o), 1);
      chk("t2_sync", 32'(sync_o), 1);
    end
    en_i = 1'b0;
    cyc();
    chk("t2_off_act", 32'(active_o), 0);
    chk("t2_off_sub", 32'(subcycle_o), 0);
    chk("t2_off_sync", 32'(sync_o), 0);

    // Subcycle 10 reduced to 2 while the count is at 7
    subcycle_cfg_i = 16'd10;
    sync_cfg_i     = 8'd1;
    en_i           = 1'b1;
    cyc();
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      cyc();
      if (subcycle_cnt_o == 16'd7) found = 1'b1;
    end
    chk("t3_reach7", 32'(found), 1);
    subcycle_cfg_i = 16'd2;
    g = 0;
    for (int i = 0; i < 60 && gapq.size() < 4; i++) begin
      cyc();
      g++;
      if (subcycle_o) begin
        gapq.push_back(g);
        g = 0;
      end
    end
`ifdef WFG_CORE_SCHEDULER_SHADOW_EN
    e_gap = '{4, 11, 3, 3};
`else
    e_gap = '{1, 3, 3, 3};
`endif
    chk_list("t3_gap", gapq, e_gap);

    // One-cycle enable drop mid-period
    cyc();
    en_i = 1'b0;
    cyc();
    chk("t4_idle_act", 32'(active_o), 0);
    en_i = 1'b1;
    cyc();
    chk("t4_act", 32'(active_o), 1);
    chk("t4_sub", 32'(subcycle_o), 1);
    chk("t4_sync", 32'(sync_o), 1);
    chk("t4_scnt", 32'(subcycle_cnt_o), 0);

    // Asynchronous reset between edges
    repeat (2) cyc();
    #2;
    rst_n = 1'b0;
    model_zero();
    #1;
    chk("t5_act", 32'(active_o), 0);
    chk("t5_sub", 32'(subcycle_o), 0);
    chk("t5_scnt", 32'(subcycle_cnt_o), 0);
    chk("t5_ycnt", 32'(sync_cnt_o), 0);
    en_i = 1'b0;
    cyc();
    rst_n = 1'b1;
    repeat (2) cyc();
    chk("t5_nostb", 32'(subcycle_o), 0);
    en_i = 1'b1;
    cyc();
    chk("t5_restart", 32'(subcycle_o), 1);

    // Random enable and cfg traffic
    for (int i = 0; i < 3000; i++) begin
      en_i = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 15) == 0)
        subcycle_cfg_i = 16'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0)
        sync_cfg_i = 8'($urandom_range(0, 3));
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
